// File: rtl/gf163_mul_seq.sv
// -----------------------------------------------------------------------------
// gf163_mul_seq
// Sequencer for a digit-serial GF(2^163) multiplier (digit size 32).
// Captures operands A and B, streams B to the datapath one digit per cycle
// (most significant digit first) while strobing the accumulator, then issues
// a single reduction strobe and holds `done` until acknowledged.
//
// Ports:
//   clk      in   clock, rising edge
//   rstn     in   asynchronous active-low reset
//   start    in   request a multiplication (taken only while ready)
//   a_in     in   operand A [M-1:0], sampled on the accepting edge
//   b_in     in   operand B [M-1:0], sampled on the accepting edge
//   abort    in   synchronous cancel back to idle, highest priority
//   res_ack  in   consumer acknowledge of done
//   ready    out  idle, able to accept start
//   busy     out  digit-serial multiply or reduction in progress
//   a_out    out  held copy of A for the datapath
//   dig_out  out  current B digit (top D bits of the B shift register)
//   acc_clr  out  first digit cycle: accumulator loads without prior shift
//   acc_en   out  accumulator update enable
//   red_en   out  one-cycle reduction/result-capture strobe
//   done     out  result valid, held until res_ack
// -----------------------------------------------------------------------------
module gf163_mul_seq #(
  parameter int M    = 163,
  parameter int D    = 32,
  parameter int NDIG = 6
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [M-1:0] a_in,
  input  logic [M-1:0] b_in,
  input  logic         abort,
  input  logic         res_ack,
  output logic         ready,
  output logic         busy,
  output logic [M-1:0] a_out,
  output logic [D-1:0] dig_out,
  output logic         acc_clr,
  output logic         acc_en,
  output logic         red_en,
  output logic         done
);

  localparam int BW = NDIG * D;  // padded B width

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_RED  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [BW-1:0]   b_sh_q, b_sh_d;
  logic [M-1:0]    a_q, a_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      b_sh_q  <= '0;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      b_sh_q  <= b_sh_d;
      a_q     <= a_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    b_sh_d  = b_sh_q;
    a_d     = a_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_in;
          // Zero-pad B on the left so the MSB digit carries only the top bits.
          b_sh_d  = {{(BW-M){1'b0}}, b_in};
          cnt_d   = '0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        b_sh_d = b_sh_q << D;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'(NDIG - 1)) begin
          state_d = S_RED;
        end
      end
      S_RED: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        // start is deliberately not looked at here, even alongside res_ack.
        if (res_ack) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // abort overrides everything, including a start seen in idle; A is kept.
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      b_sh_d  = '0;
      a_d     = a_q;
    end
  end

  // Moore outputs: decoded only from registered state, counter and shifter.
  assign ready   = (state_q == S_IDLE);
  assign busy    = (state_q == S_MUL) || (state_q == S_RED);
  assign done    = (state_q == S_DONE);
  assign acc_en  = (state_q == S_MUL);
  assign acc_clr = (state_q == S_MUL) && (cnt_q == 3'd0);
  assign red_en  = (state_q == S_RED);
  assign dig_out = b_sh_q[BW-1 -: D];
  assign a_out   = a_q;

endmodule
